// File: rtl/des_pkg.sv
// Shared DES front-end definitions: datapath widths, padding modes and the
// block payload carried from the packer to its output register.
package des_pkg;

    localparam int unsigned DES_BLOCK_W   = 64;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BYTES_PER_BLK = DES_BLOCK_W / BYTE_W;
    localparam int unsigned CNT_W         = 3;
    localparam int unsigned PAD_CNT_W     = 4;

    localparam int unsigned PAD_ZERO  = 0;
    localparam int unsigned PAD_PKCS5 = 1;

    localparam logic [BYTE_W-1:0] PKCS_FULL_PAD = 8'h08;

    // One assembled block; data[63] is DES bit 1 (MSB of the first byte).
    typedef struct packed {
        logic [DES_BLOCK_W-1:0] data;
        logic                   last;
        logic [PAD_CNT_W-1:0]   pad_cnt;
    } des_blk_t;

    // Value written into each pad byte for the given mode and pad count.
    function automatic logic [BYTE_W-1:0] pad_byte(input int unsigned          mode,
                                                   input logic [PAD_CNT_W-1:0] cnt);
        return (mode == PAD_PKCS5) ? BYTE_W'(cnt) : '0;
    endfunction

endpackage

// File: rtl/des_blk_out_reg.sv
// Single-entry valid/ready output register for assembled DES blocks.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load_i      capture blk_i this edge (only asserted when empty or draining)
//   blk_i       incoming block payload
//   ready_i     consumer accepts the held block
//   valid_o     held block is valid
//   blk_o       held block payload
module des_blk_out_reg
    import des_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load_i,
    input  des_blk_t blk_i,
    input  logic     ready_i,
    output logic     valid_o,
    output des_blk_t blk_o
);

    logic     valid_q, valid_d;
    des_blk_t blk_q, blk_d;

    // Load wins over drain so back-to-back blocks keep valid high.
    always_comb begin
        valid_d = valid_q;
        blk_d   = blk_q;
        if (load_i) begin
            valid_d = 1'b1;
            blk_d   = blk_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            valid_q <= valid_d;
            blk_q   <= blk_d;
        end
    end

    assign valid_o = valid_q;
    assign blk_o   = blk_q;

endmodule

// File: rtl/des_block_packer.sv
// Byte-serial DES front end: packs an 8-bit plaintext stream into 64-bit
// blocks, pads the final block (zero or PKCS#5) and presents blocks on a
// valid/ready interface. blk_data[63] is DES bit 1, blk_data[0] is bit 64.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_data/valid/last     byte stream in; in_data[7] is the first bit
//   in_ready               byte can be accepted this cycle
//   blk_data/valid/ready   block stream out
//   blk_last               final block of the message
//   blk_pad_cnt            pad bytes contained in the block (0..8)
module des_block_packer
    import des_pkg::*;
#(
    parameter int unsigned PAD_MODE = PAD_ZERO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [DES_BLOCK_W-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   blk_last,
    output logic [PAD_CNT_W-1:0]   blk_pad_cnt
);

    typedef logic [BYTES_PER_BLK-1:0][BYTE_W-1:0] lanes_t;

    localparam des_blk_t EXTRA_BLK = '{
        data:    {BYTES_PER_BLK{PKCS_FULL_PAD}},
        last:    1'b1,
        pad_cnt: PAD_CNT_W'(BYTES_PER_BLK)
    };

    logic [CNT_W-1:0] cnt_q, cnt_d;
    des_blk_t         asm_q, asm_d;       // partial block, or complete block when asm_full_q
    logic             asm_full_q, asm_full_d;
    logic             extra_q, extra_d;   // PKCS#5 all-pad block still owed

    logic             out_valid;
    des_blk_t         out_blk;
    logic             out_free_c;
    logic             load_c;
    des_blk_t         load_blk_c;

    logic             accept_c;
    logic             is_k7_c;
    logic             complete_c;
    logic             extra_set_c;
    logic [CNT_W-1:0] lane_c;
    logic [PAD_CNT_W-1:0] pad_cnt_c;
    logic [BYTE_W-1:0]    pad_val_c;
    lanes_t           lanes_c;
    des_blk_t         new_blk_c;

    assign out_free_c  = !out_valid || blk_ready;
    assign in_ready    = !extra_q && (!asm_full_q || out_free_c);
    assign accept_c    = in_valid && in_ready;
    assign is_k7_c     = (cnt_q == CNT_W'(BYTES_PER_BLK - 1));
    assign complete_c  = accept_c && (is_k7_c || in_last);
    assign extra_set_c = complete_c && in_last && is_k7_c && (PAD_MODE == PAD_PKCS5);

    // Merge the incoming byte into the assembly; later lanes take the pad value.
    // Byte k lives in lane 7-k so the first byte lands in the MSBs.
    always_comb begin
        pad_cnt_c = in_last ? (PAD_CNT_W'(BYTES_PER_BLK - 1) - PAD_CNT_W'(cnt_q)) : '0;
        pad_val_c = pad_byte(PAD_MODE, pad_cnt_c);
        lane_c    = CNT_W'(BYTES_PER_BLK - 1) - cnt_q;
        lanes_c   = asm_q.data;
        for (int unsigned l = 0; l < BYTES_PER_BLK; l++) begin
            if (CNT_W'(l) == lane_c) begin
                lanes_c[CNT_W'(l)] = in_data;
            end else if (CNT_W'(l) < lane_c) begin
                lanes_c[CNT_W'(l)] = pad_val_c;
            end
        end
        new_blk_c.data    = lanes_c;
        // A full PKCS#5 final block defers 'last' to the extra block behind it.
        new_blk_c.last    = in_last && !((PAD_MODE == PAD_PKCS5) && is_k7_c);
        new_blk_c.pad_cnt = pad_cnt_c;
    end

    // Output source priority: held block, then owed extra block, then fresh completion.
    always_comb begin
        load_c     = 1'b0;
        load_blk_c = new_blk_c;
        if (asm_full_q) begin
            load_c     = out_free_c;
            load_blk_c = asm_q;
        end else if (extra_q) begin
            load_c     = out_free_c;
            load_blk_c = EXTRA_BLK;
        end else if (complete_c) begin
            load_c     = out_free_c;
        end
    end

    // Counter, assembly register and pending-block flags.
    always_comb begin
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        asm_full_d = asm_full_q;
        extra_d    = extra_q;
        if (asm_full_q && out_free_c) begin
            asm_full_d = 1'b0;
        end
        if (extra_q && !asm_full_q && out_free_c) begin
            extra_d = 1'b0;
        end
        if (accept_c) begin
            cnt_d = complete_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
            asm_d = new_blk_c;
            // Completion that could not go straight out is parked here.
            if (complete_c && !(load_c && !asm_full_q)) begin
                asm_full_d = 1'b1;
            end
        end
        if (extra_set_c) begin
            extra_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            asm_full_q <= 1'b0;
            extra_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            asm_full_q <= asm_full_d;
            extra_q    <= extra_d;
        end
    end

    des_blk_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .blk_i   (load_blk_c),
        .ready_i (blk_ready),
        .valid_o (out_valid),
        .blk_o   (out_blk)
    );

    assign blk_valid   = out_valid;
    assign blk_data    = out_blk.data;
    assign blk_last    = out_blk.last;
    assign blk_pad_cnt = out_blk.pad_cnt;

endmodule

// File: tb/tb_des_block_packer.sv
// Bench for des_block_packer: directed table plus randomized traffic on a
// zero-padding and a PKCS#5 instance, checked against a message-level model.
module tb_des_block_packer;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [3:0]  p;
    } blk_t;

    typedef struct {
        int          mode;
        int          n;
        logic [63:0] msg;
        int          nblk;
        logic [63:0] d0;
        logic        l0;
        logic [3:0]  p0;
        logic [63:0] d1;
        logic        l1;
        logic [3:0]  p1;
        int          ir_low;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic [63:0] blk_data0, blk_data1;
    logic        blk_valid0, blk_valid1;
    logic        blk_ready0, blk_ready1;
    logic        blk_last0, blk_last1;
    logic [3:0]  blk_pad0, blk_pad1;

    always #5 clk = ~clk;

    des_block_packer #(.PAD_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid0),
        .in_last(in_last), .in_ready(in_ready0), .blk_data(blk_data0),
        .blk_valid(blk_valid0), .blk_ready(blk_ready0), .blk_last(blk_last0),
        .blk_pad_cnt(blk_pad0)
    );

    des_block_packer #(.PAD_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid1),
        .in_last(in_last), .in_ready(in_ready1), .blk_data(blk_data1),
        .blk_valid(blk_valid1), .blk_ready(blk_ready1), .blk_last(blk_last1),
        .blk_pad_cnt(blk_pad1)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   last_acc_cyc;
    int   acc_cnt;
    int   ir_low_cnt;
    bit   hold_pending;
    blk_t hold_val;

    logic [7:0] src_d[$];
    logic       src_l[$];
    blk_t       got[$];
    int         got_cyc[$];
    blk_t       exp_q[$];
    vec_t       vt[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Message-level reference: split into 8-byte blocks, then pad the tail.
    task automatic model(input int m, input logic [7:0] msg[$]);
        int   n, full, rem, pc;
        blk_t b;
        n    = msg.size();
        full = n / 8;
        rem  = n % 8;
        for (int c = 0; c < full; c++) begin
            b.d = '0;
            for (int i = 0; i < 8; i++) b.d = (b.d << 8) | 64'(msg[c*8+i]);
            b.l = (c == full - 1) && (rem == 0) && (m == 0);
            b.p = 4'd0;
            exp_q.push_back(b);
        end
        if (rem > 0) begin
            pc  = 8 - rem;
            b.d = '0;
            for (int i = 0; i < 8; i++)
                b.d = (b.d << 8) | ((i < rem) ? 64'(msg[full*8+i]) : ((m == 1) ? 64'(pc) : 64'd0));
            b.l = 1'b1;
            b.p = 4'(pc);
            exp_q.push_back(b);
        end else if (m == 1) begin
            b.d = 64'h0808080808080808;
            b.l = 1'b1;
            b.p = 4'd8;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_msg(input int m, input logic [7:0] msg[$]);
        for (int i = 0; i < msg.size(); i++) begin
            src_d.push_back(msg[i]);
            src_l.push_back(i == msg.size() - 1);
        end
        model(m, msg);
    endtask

    // One clock cycle: drive at negedge, observe 1 time unit later, advance.
    task automatic cycle(input int m, input bit want_valid, input bit rdy);
        logic ir, bv;
        blk_t b;
        bit   pres;
        pres       = want_valid && (src_d.size() > 0);
        in_data    = pres ? src_d[0] : 8'h00;
        in_last    = pres ? src_l[0] : 1'b0;
        in_valid0  = pres && (m == 0);
        in_valid1  = pres && (m == 1);
        blk_ready0 = (m == 0) ? rdy : 1'b1;
        blk_ready1 = (m == 1) ? rdy : 1'b1;
        #1;
        ir = (m == 1) ? in_ready1 : in_ready0;
        bv = (m == 1) ? blk_valid1 : blk_valid0;
        b  = (m == 1) ? {blk_data1, blk_last1, blk_pad1} : {blk_data0, blk_last0, blk_pad0};
        if (hold_pending) begin
            check("hold_valid", 64'(bv), 64'd1);
            check("hold_data", b.d, hold_val.d);
            check("hold_meta", {59'd0, b.l, b.p}, {59'd0, hold_val.l, hold_val.p});
        end
        hold_pending = bv && !rdy;
        hold_val     = b;
        if (!ir) ir_low_cnt++;
        if (pres && ir) begin
            void'(src_d.pop_front());
            void'(src_l.pop_front());
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (bv && rdy) begin
            got.push_back(b);
            got_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_all();
        src_d.delete(); src_l.delete(); got.delete(); got_cyc.delete(); exp_q.delete();
        acc_cnt = 0; ir_low_cnt = 0; hold_pending = 0;
    endtask

    task automatic run_until(input int m, input int pv, input int pr, input int limit);
        int guard = 0;
        while ((src_d.size() > 0 || got.size() < exp_q.size()) && guard < limit) begin
            cycle(m, $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
            guard++;
        end
        repeat (3) cycle(m, 1'b0, 1'b1);
        check("block_count", 64'(got.size()), 64'(exp_q.size()));
    endtask

    task automatic compare_blocks(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                check({tag, "_data"}, got[i].d, exp_q[i].d);
                check({tag, "_meta"}, {59'd0, got[i].l, got[i].p}, {59'd0, exp_q[i].l, exp_q[i].p});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] msg[$];
        int         m;

        vt[0] = '{0, 8, 64'h0123456789ABCDEF, 1, 64'h0123456789ABCDEF, 1'b1, 4'd0, 64'h0, 1'b0, 4'd0, 0};
        vt[1] = '{0, 3, 64'hAABBCC0000000000, 1, 64'hAABBCC0000000000, 1'b1, 4'd5, 64'h0, 1'b0, 4'd0, 0};
        vt[2] = '{1, 8, 64'h1122334455667788, 2, 64'h1122334455667788, 1'b0, 4'd0,
                  64'h0808080808080808, 1'b1, 4'd8, 1};
        vt[3] = '{1, 2, 64'hDEAD000000000000, 1, 64'hDEAD060606060606, 1'b1, 4'd6, 64'h0, 1'b0, 4'd0, 0};

        rst_n = 1'b0; in_data = '0; in_last = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; blk_ready0 = 1'b1; blk_ready1 = 1'b1;
        clear_all();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {62'd0, blk_valid0, blk_valid1}, 64'd0);
        check("rst_data0", blk_data0, 64'd0);
        check("rst_data1", blk_data1, 64'd0);
        check("rst_meta", {54'd0, blk_last0, blk_last1, blk_pad0, blk_pad1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {62'd0, in_ready0, in_ready1}, 64'd3);
        @(negedge clk);

        // Directed table, consumer always ready.
        for (int v = 0; v < 4; v++) begin
            clear_all();
            msg.delete();
            for (int i = 0; i < vt[v].n; i++) msg.push_back(vt[v].msg[63 - 8*i -: 8]);
            for (int i = 0; i < msg.size(); i++) begin
                src_d.push_back(msg[i]);
                src_l.push_back(i == msg.size() - 1);
            end
            repeat (14) cycle(vt[v].mode, 1'b1, 1'b1);
            check($sformatf("t%0d_nblk", v), 64'(got.size()), 64'(vt[v].nblk));
            check($sformatf("t%0d_ir_low", v), 64'(ir_low_cnt), 64'(vt[v].ir_low));
            if (got.size() > 0) begin
                check($sformatf("t%0d_b0_data", v), got[0].d, vt[v].d0);
                check($sformatf("t%0d_b0_meta", v), {59'd0, got[0].l, got[0].p}, {59'd0, vt[v].l0, vt[v].p0});
                check($sformatf("t%0d_b0_lat", v), 64'(got_cyc[0]), 64'(last_acc_cyc + 1));
            end
            if (vt[v].nblk == 2 && got.size() > 1) begin
                check($sformatf("t%0d_b1_data", v), got[1].d, vt[v].d1);
                check($sformatf("t%0d_b1_meta", v), {59'd0, got[1].l, got[1].p}, {59'd0, vt[v].l1, vt[v].p1});
                check($sformatf("t%0d_b1_lat", v), 64'(got_cyc[1]), 64'(got_cyc[0] + 1));
            end
        end

        // Consumer stalled for 20 cycles under a continuous 24-byte stream.
        clear_all();
        msg.delete();
        for (int i = 0; i < 24; i++) msg.push_back(8'($urandom));
        send_msg(0, msg);
        repeat (20) cycle(0, 1'b1, 1'b0);
        check("stall_accepted", 64'(acc_cnt), 64'd16);
        check("stall_ir_low", 64'(ir_low_cnt), 64'd4);
        run_until(0, 100, 100, 200);
        compare_blocks("stall");

        // Reset with one block on the output and five bytes in assembly.
        clear_all();
        msg.delete();
        for (int i = 0; i < 13; i++) msg.push_back(8'($urandom));
        for (int i = 0; i < 13; i++) begin
            src_d.push_back(msg[i]);
            src_l.push_back(1'b0);
        end
        repeat (13) cycle(0, 1'b1, 1'b0);
        check("pre_rst_valid", 64'(blk_valid0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(blk_valid0), 64'd0);
        check("midrst_data", blk_data0, 64'd0);
        check("midrst_meta", {59'd0, blk_last0, blk_pad0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_all();
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(8'($urandom));
        send_msg(0, msg);
        run_until(0, 100, 100, 100);
        compare_blocks("post_rst");

        // Randomized messages with random valid gaps and backpressure.
        for (m = 0; m < 2; m++) begin
            clear_all();
            for (int k = 0; k < 12; k++) begin
                msg.delete();
                for (int i = 0; i < int'($urandom_range(1, 20)); i++) msg.push_back(8'($urandom));
                send_msg(m, msg);
            end
            run_until(m, 70, 60, 3000);
            compare_blocks($sformatf("rand_m%0d", m));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_block_packer.md
Name: des_block_packer

Overview:
- Byte-serial front end of the DES datapath, sitting directly upstream of the initial permutation.
- Collects an 8-bit plaintext stream into 64-bit blocks and pads the final partial block, either with zeros or PKCS#5 style.
- Presents each block on a valid/ready interface in DES bit order: bit 1 is the leftmost bit and the MSB of the first byte.
- Double-buffered (assembly register plus output register), so input continues while the consumer stalls for one block.

Parameters:
- PAD_MODE, default 0, padding scheme: 0 = zero padding, 1 = PKCS#5 (pad value = number of pad bytes).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  plaintext byte; in_data[7] is the first-transmitted bit.
- in_valid  in  1  byte present.
- in_last  in  1  byte is the final byte of the message; qualified by in_valid.
- in_ready  out  1  packer can accept a byte this cycle.
- blk_data  out  [1:64]  assembled block, DES bit numbering.
- blk_valid  out  1  blk_data, blk_last and blk_pad_cnt are valid.
- blk_ready  in  1  consumer accepts the block.
- blk_last  out  1  block is the final block of the message.
- blk_pad_cnt  out  4  number of pad bytes in the block (0..8).

Behaviour:
- Reset (async, rst_n=0): blk_data=0, blk_valid=0, blk_last=0, blk_pad_cnt=0, byte counter=0, assembly empty, no extra block pending. in_ready=1 from the first cycle after reset release.
- Reset mid-operation: any partial or held block is discarded; no output is produced for it.
- Byte accept: occurs when in_valid & in_ready. Byte k of a block (k = 0..7) is written to blk bits [8k+1 : 8k+8], with in_data[7] going to bit 8k+1.
- Completion: a block is complete when byte k=7 is accepted, or when in_last is accepted at any k.
  - On in_last with k<7: bytes k+1..7 are pad bytes and pad_cnt = 7-k.
  - Pad byte value is 8'h00 when PAD_MODE=0, and pad_cnt when PAD_MODE=1.
  - The completed block carries last=1.
- PKCS#5 full final block: with PAD_MODE=1 and in_last on k=7, the data block carries last=0, pad_cnt=0. An extra block of eight 8'h08 bytes (pad_cnt=8, last=1) is generated automatically behind it.
- Zero mode, in_last on k=7: last=1, pad_cnt=0, no extra block.
- Transfer to output register: a complete block moves to the output register on the clock edge where it completes (or any later edge) if the output register is empty or blk_ready is high that cycle.
  - Latency: completing byte accepted in cycle N, blk_valid=1 in cycle N+1 when unobstructed.
- Output hold: blk_valid stays high and blk_data, blk_last and blk_pad_cnt stay stable until blk_valid & blk_ready. blk_valid drops the cycle after acceptance unless the next block moves in on the same edge (back-to-back allowed).
- in_ready is low only while:
  - a complete block is held in the assembly register because the output register is occupied and not draining, or
  - a PKCS#5 extra block is pending or held.
- in_ready has no combinational path from in_valid; it may depend combinationally on blk_ready.
- Throughput: with blk_ready tied high, 1 byte/cycle sustained with no bubbles, including across block boundaries. The extra PKCS#5 block costs exactly one in_ready-low cycle.
- Byte counter wraps 7->0 after every completion. After a last block, the next accepted byte starts a new message at k=0.
- An in_last pulse always accompanies a real data byte; empty messages are not supported.

Decomposition:
- Shared des_pkg holds:
  - DES_BLOCK_W=64 and BYTE_W=8;
  - pad-mode constants PAD_ZERO=0 and PAD_PKCS5=1;
  - PKCS_FULL_PAD=8'h08.
- Natural sub-module: des_blk_out_reg, the single-entry valid/ready output register holding data, last and pad_cnt. The packer owns the byte counter, assembly register, padding logic and extra-block flag.

Test Plan:
- Bytes 01 23 45 67 89 AB CD EF, last on EF, blk_ready=1 -> one block, blk_data=64'h0123456789ABCDEF, blk_last=1, pad_cnt=0, blk_valid one cycle after EF accept.
- PAD_MODE=0, bytes AA BB CC with last on CC -> blk_data=64'hAABBCC0000000000, pad_cnt=5, blk_last=1.
- PAD_MODE=1, 8 bytes 11..88 with last on 88 -> block 64'h1122334455667788 (last=0, pad_cnt=0), then 64'h0808080808080808 (last=1, pad_cnt=8). in_ready low exactly one cycle.
- PAD_MODE=1, bytes DE AD with last on AD -> 64'hDEAD060606060606, pad_cnt=6, last=1.
- 24 bytes continuous with blk_ready=0 for 20 cycles -> first block held stable on the output, second block held in assembly, in_ready low from the 17th byte onward. After blk_ready=1: three blocks in order, none lost.
- Reset asserted after 5 bytes of a block -> all outputs 0 immediately. Next 8 bytes after release form a fresh block starting at bit 1.
